// File: rtl/fwd_scoreboard_pkg.sv
// Shared types for the EX forwarding scoreboard: FSM states and the in-flight write entry.
package fwd_pkg;
  localparam int SB_REG_W = 8;
  localparam int FWD_RF   = 0;

  typedef enum logic [1:0] {
    RUN  = 2'd0,
    LU   = 2'd1,
    MISS = 2'd2
  } fwd_state_t;

  typedef struct packed {
    logic                valid;
    logic                regwr;
    logic                load;
    logic                ready;
    logic [SB_REG_W-1:0] dest;
  } sb_entry_t;
endpackage

// File: rtl/fwd_scoreboard_if.sv
// EX/ID operand info into the scoreboard, forward selects and stall back out.
interface fwd_if #(
  parameter int REG_W   = 5,
  parameter int NUM_SRC = 2,
  parameter int SEL_W   = 2,
  parameter int CNT_W   = 16
);
  logic                       pipe_en;
  logic                       flush;
  logic                       ex_valid;
  logic                       ex_regwr;
  logic                       ex_memtoreg;
  logic [REG_W-1:0]           ex_dest;
  logic [NUM_SRC*REG_W-1:0]   ex_src;
  logic [NUM_SRC*REG_W-1:0]   id_src;
  logic [NUM_SRC-1:0]         id_src_en;
  logic                       dhit;
  logic [NUM_SRC*SEL_W-1:0]   fwd_sel;
  logic                       stall;
  logic [CNT_W-1:0]           stall_cnt;
  logic [1:0]                 state;

  modport fwd (
    input  pipe_en, flush, ex_valid, ex_regwr, ex_memtoreg, ex_dest, ex_src,
           id_src, id_src_en, dhit,
    output fwd_sel, stall, stall_cnt, state
  );

  modport tb (
    output pipe_en, flush, ex_valid, ex_regwr, ex_memtoreg, ex_dest, ex_src,
           id_src, id_src_en, dhit,
    input  fwd_sel, stall, stall_cnt, state
  );
endinterface

// File: rtl/fwd_scoreboard_match.sv
// One EX operand against all tracked stages; youngest matching producer wins.
module fwd_match
  import fwd_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int SEL_W = 2
) (
  input  sb_entry_t [DEPTH:1]   ent_i,
  input  logic [SB_REG_W-1:0]   src_i,
  output logic [SEL_W-1:0]      sel_o,
  output logic                  unrdy_o
);
  // Scan oldest to youngest so the youngest hit overwrites.
  always_comb begin
    sel_o   = SEL_W'(FWD_RF);
    unrdy_o = 1'b0;
    for (int k = DEPTH; k >= 1; k--) begin
      if (ent_i[k].valid && ent_i[k].regwr && ent_i[k].dest == src_i && src_i != '0) begin
        sel_o   = SEL_W'(k);
        unrdy_o = ent_i[k].load & ~ent_i[k].ready;
      end
    end
  end
endmodule

// File: rtl/fwd_scoreboard.sv
// Shift-register scoreboard of in-flight writes after EX, per-operand forward selects, load-use/miss stall FSM.
module fwd_scoreboard
  import fwd_pkg::*;
#(
  parameter int REG_W   = 5,
  parameter int NUM_SRC = 2,
  parameter int DEPTH   = 2,
  parameter int SEL_W   = $clog2(DEPTH+1),
  parameter int CNT_W   = 16
) (
  input logic CLK,
  input logic RST,
  fwd_if.fwd  bus
);
  sb_entry_t [DEPTH:1] sb_q, sb_d, sb_eff;
  sb_entry_t           ex_e;
  fwd_state_t          state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [NUM_SRC-1:0][SEL_W-1:0] sel;
  logic [NUM_SRC-1:0]  unrdy;
  logic                ex_live, lu_det, miss_fwd, e1_miss, stall;

  assign ex_live = bus.ex_valid & ~bus.flush;

  always_comb begin
    ex_e       = '0;
    ex_e.valid = ex_live;
    ex_e.regwr = bus.ex_regwr;
    ex_e.load  = bus.ex_memtoreg;
    ex_e.ready = ~bus.ex_memtoreg;
    ex_e.dest  = SB_REG_W'(bus.ex_dest);
  end

  // Load data returning this cycle counts as ready for forwarding and is latched into the entry.
  always_comb begin
    sb_eff          = sb_q;
    sb_eff[1].ready = sb_q[1].ready | (sb_q[1].load & bus.dhit);
  end

  assign e1_miss = sb_q[1].valid & sb_q[1].load & ~sb_eff[1].ready;

  for (genvar i = 0; i < NUM_SRC; i++) begin : g_src
    fwd_match #(.DEPTH(DEPTH), .SEL_W(SEL_W)) u_match (
      .ent_i   (sb_eff),
      .src_i   (SB_REG_W'(bus.ex_src[i*REG_W +: REG_W])),
      .sel_o   (sel[i]),
      .unrdy_o (unrdy[i])
    );
    assign bus.fwd_sel[i*SEL_W +: SEL_W] = sel[i];
  end

  assign miss_fwd = ex_live & (|unrdy);

  always_comb begin
    lu_det = 1'b0;
    for (int i = 0; i < NUM_SRC; i++)
      if (bus.id_src_en[i] && bus.id_src[i*REG_W +: REG_W] == bus.ex_dest)
        lu_det = 1'b1;
    lu_det = lu_det & ex_live & bus.ex_memtoreg & (bus.ex_dest != '0);
  end

  always_ff @(posedge CLK) begin
    if (RST) state_q <= RUN;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      RUN:     if (lu_det) state_d = LU;
               else if (miss_fwd) state_d = MISS;
      LU:      state_d = e1_miss ? MISS : RUN;
      MISS:    if (bus.dhit) state_d = RUN;
      default: state_d = RUN;
    endcase
  end

  always_comb begin
    stall = 1'b0;
    case (state_q)
      RUN:     stall = lu_det | miss_fwd;
      LU:      stall = e1_miss | miss_fwd;
      MISS:    stall = ~bus.dhit;
      default: stall = 1'b0;
    endcase
  end

  // On a load-use stall the load itself still moves to MEM; only the dependent in ID is held.
  always_comb begin
    sb_d    = sb_q;
    sb_d[1] = sb_eff[1];
    if (bus.pipe_en) begin
      for (int k = DEPTH; k >= 2; k--) sb_d[k] = sb_eff[k-1];
      sb_d[1] = (stall && !(state_q == RUN && lu_det)) ? '0 : ex_e;
    end
  end

  assign cnt_d = (stall && cnt_q != '1) ? cnt_q + 1'b1 : cnt_q;

  always_ff @(posedge CLK) begin
    if (RST) begin
      sb_q  <= '0;
      cnt_q <= '0;
    end else begin
      sb_q  <= sb_d;
      cnt_q <= cnt_d;
    end
  end

  assign bus.stall     = stall;
  assign bus.stall_cnt = cnt_q;
  assign bus.state     = state_q;
endmodule

// File: tb/tb_fwd_scoreboard.sv
// Directed bench: default scoreboard (ia) plus a DEPTH=3 / CNT_W=4 instance (ib) on the same stimulus.
module tb_fwd_scoreboard;
  logic CLK = 1'b0;
  logic RST;
  logic pipe_en, flush, ex_valid, ex_regwr, ex_memtoreg, dhit;
  logic [4:0] ex_dest;
  logic [9:0] ex_src, id_src;
  logic [1:0] id_src_en;
  int total = 0;
  int bad   = 0;

  always #5 CLK = ~CLK;

  fwd_if #(.REG_W(5), .NUM_SRC(2), .SEL_W(2), .CNT_W(16)) ia ();
  fwd_if #(.REG_W(5), .NUM_SRC(2), .SEL_W(2), .CNT_W(4))  ib ();

  assign ia.pipe_en = pipe_en;     assign ib.pipe_en = pipe_en;
  assign ia.flush = flush;         assign ib.flush = flush;
  assign ia.ex_valid = ex_valid;   assign ib.ex_valid = ex_valid;
  assign ia.ex_regwr = ex_regwr;   assign ib.ex_regwr = ex_regwr;
  assign ia.ex_memtoreg = ex_memtoreg; assign ib.ex_memtoreg = ex_memtoreg;
  assign ia.ex_dest = ex_dest;     assign ib.ex_dest = ex_dest;
  assign ia.ex_src = ex_src;       assign ib.ex_src = ex_src;
  assign ia.id_src = id_src;       assign ib.id_src = id_src;
  assign ia.id_src_en = id_src_en; assign ib.id_src_en = id_src_en;
  assign ia.dhit = dhit;           assign ib.dhit = dhit;

  fwd_scoreboard dut (.CLK(CLK), .RST(RST), .bus(ia.fwd));
  fwd_scoreboard #(.DEPTH(3), .CNT_W(4)) dut3 (.CLK(CLK), .RST(RST), .bus(ib.fwd));

  task automatic ex(input logic v, input logic rw, input logic ld, input logic [4:0] d,
                    input logic [4:0] s0, input logic [4:0] s1);
    ex_valid = v; ex_regwr = rw; ex_memtoreg = ld; ex_dest = d; ex_src = {s1, s0};
  endtask

  task automatic idle();
    pipe_en = 1'b1; flush = 1'b0; dhit = 1'b0;
    ex(0, 0, 0, 5'd0, 5'd0, 5'd0);
    id_src = '0; id_src_en = '0;
  endtask

  task automatic step();
    @(posedge CLK); #1;
  endtask

  task automatic settle();
    #2;
  endtask

  task automatic do_reset();
    RST = 1'b1; idle(); step(); step();
    RST = 1'b0;
  endtask

  task automatic test_reset();
    RST = 1'b1;
    pipe_en = 1'b1; flush = 1'b0; dhit = 1'b0;
    ex(1, 1, 1, 5'd4, 5'd4, 5'd4);
    id_src = {5'd4, 5'd4}; id_src_en = 2'b11;
    step(); step();
    RST = 1'b0; idle(); settle();
    total++; if (ia.fwd_sel !== 4'd0) begin bad++; $display("FAIL rst_fwd got %0d want 0", ia.fwd_sel); end
    total++; if (ia.stall !== 1'b0) begin bad++; $display("FAIL rst_stall got %0d want 0", ia.stall); end
    total++; if (ia.stall_cnt !== 16'd0) begin bad++; $display("FAIL rst_cnt got %0d want 0", ia.stall_cnt); end
    total++; if (ia.state !== 2'd0) begin bad++; $display("FAIL rst_state got %0d want 0", ia.state); end
    total++; if (ib.stall_cnt !== 4'd0) begin bad++; $display("FAIL rst_cnt3 got %0d want 0", ib.stall_cnt); end
  endtask

  task automatic test_alu_chain();
    do_reset();
    ex(1, 1, 0, 5'd3, 5'd1, 5'd2); settle();
    total++; if (ia.fwd_sel !== 4'd0) begin bad++; $display("FAIL alu_c0 got %0d want 0", ia.fwd_sel); end
    step();
    ex(1, 1, 0, 5'd6, 5'd3, 5'd7); settle();
    total++; if (ia.fwd_sel[1:0] !== 2'd1) begin bad++; $display("FAIL alu_mem got %0d want 1", ia.fwd_sel[1:0]); end
    total++; if (ia.fwd_sel[3:2] !== 2'd0) begin bad++; $display("FAIL alu_nomatch got %0d want 0", ia.fwd_sel[3:2]); end
    step();
    ex(1, 1, 0, 5'd8, 5'd3, 5'd6); settle();
    total++; if (ia.fwd_sel[1:0] !== 2'd2) begin bad++; $display("FAIL alu_wb got %0d want 2", ia.fwd_sel[1:0]); end
    total++; if (ia.fwd_sel[3:2] !== 2'd1) begin bad++; $display("FAIL alu_op1 got %0d want 1", ia.fwd_sel[3:2]); end
    step();
    ex(1, 0, 0, 5'd0, 5'd3, 5'd0); settle();
    total++; if (ia.fwd_sel[1:0] !== 2'd0) begin bad++; $display("FAIL alu_gone got %0d want 0", ia.fwd_sel[1:0]); end
    total++; if (ib.fwd_sel[1:0] !== 2'd3) begin bad++; $display("FAIL alu_d3 got %0d want 3", ib.fwd_sel[1:0]); end
    step();
  endtask

  task automatic test_youngest();
    do_reset();
    ex(1, 1, 0, 5'd5, 5'd1, 5'd1); step();
    ex(1, 1, 0, 5'd5, 5'd5, 5'd0); settle();
    total++; if (ia.fwd_sel[1:0] !== 2'd1) begin bad++; $display("FAIL yng_c1 got %0d want 1", ia.fwd_sel[1:0]); end
    step();
    ex(1, 1, 0, 5'd0, 5'd5, 5'd0); settle();
    total++; if (ia.fwd_sel[1:0] !== 2'd1) begin bad++; $display("FAIL yng_both got %0d want 1", ia.fwd_sel[1:0]); end
    step();
    ex(1, 0, 0, 5'd0, 5'd0, 5'd5); settle();
    total++; if (ia.fwd_sel[1:0] !== 2'd0) begin bad++; $display("FAIL yng_r0 got %0d want 0", ia.fwd_sel[1:0]); end
    total++; if (ia.fwd_sel[3:2] !== 2'd2) begin bad++; $display("FAIL yng_wb got %0d want 2", ia.fwd_sel[3:2]); end
    step();
  endtask

  task automatic lu_start();
    do_reset();
    ex(1, 1, 1, 5'd4, 5'd1, 5'd0);
    id_src = {5'd0, 5'd4}; id_src_en = 2'b01; settle();
    total++; if (ia.stall !== 1'b1) begin bad++; $display("FAIL lu_detect got %0d want 1", ia.stall); end
    total++; if (ia.state !== 2'd0) begin bad++; $display("FAIL lu_detect_st got %0d want 0", ia.state); end
    step();
    id_src = '0; id_src_en = '0;
    ex(1, 1, 0, 5'd9, 5'd4, 5'd0);
  endtask

  task automatic test_lu_hit();
    lu_start();
    dhit = 1'b1; settle();
    total++; if (ia.state !== 2'd1) begin bad++; $display("FAIL hit_st got %0d want 1", ia.state); end
    total++; if (ia.stall !== 1'b0) begin bad++; $display("FAIL hit_stall got %0d want 0", ia.stall); end
    total++; if (ia.fwd_sel[1:0] !== 2'd1) begin bad++; $display("FAIL hit_fwd got %0d want 1", ia.fwd_sel[1:0]); end
    step();
    idle(); settle();
    total++; if (ia.state !== 2'd0) begin bad++; $display("FAIL hit_run got %0d want 0", ia.state); end
    total++; if (ia.stall_cnt !== 16'd1) begin bad++; $display("FAIL hit_cnt got %0d want 1", ia.stall_cnt); end
  endtask

  task automatic test_lu_miss();
    logic [1:0] exp_st [4] = '{2'd1, 2'd2, 2'd2, 2'd2};
    logic       exp_sl [4] = '{1'b1, 1'b1, 1'b1, 1'b0};
    lu_start();
    for (int c = 0; c < 4; c++) begin
      dhit = (c == 3); pipe_en = (c == 3); settle();
      total++; if (ia.state !== exp_st[c]) begin bad++; $display("FAIL miss_st%0d got %0d want %0d", c, ia.state, exp_st[c]); end
      total++; if (ia.stall !== exp_sl[c]) begin bad++; $display("FAIL miss_stall%0d got %0d want %0d", c, ia.stall, exp_sl[c]); end
      step();
    end
    idle(); settle();
    total++; if (ia.state !== 2'd0) begin bad++; $display("FAIL miss_run got %0d want 0", ia.state); end
    total++; if (ia.stall_cnt !== 16'd4) begin bad++; $display("FAIL miss_cnt got %0d want 4", ia.stall_cnt); end
  endtask

  task automatic test_flush();
    do_reset();
    flush = 1'b1;
    ex(1, 1, 1, 5'd4, 5'd1, 5'd0);
    id_src = {5'd0, 5'd4}; id_src_en = 2'b01; settle();
    total++; if (ia.stall !== 1'b0) begin bad++; $display("FAIL flush_stall got %0d want 0", ia.stall); end
    step();
    idle(); ex(1, 0, 0, 5'd0, 5'd4, 5'd4); settle();
    total++; if (ia.fwd_sel !== 4'd0) begin bad++; $display("FAIL flush_bubble got %0d want 0", ia.fwd_sel); end
    total++; if (ia.state !== 2'd0) begin bad++; $display("FAIL flush_st got %0d want 0", ia.state); end
    step();
  endtask

  task automatic test_saturation();
    lu_start();
    pipe_en = 1'b0; dhit = 1'b0;
    for (int c = 0; c < 20; c++) step();
    settle();
    total++; if (ib.stall_cnt !== 4'd15) begin bad++; $display("FAIL sat_cnt got %0d want 15", ib.stall_cnt); end
    total++; if (ia.stall_cnt !== 16'd21) begin bad++; $display("FAIL sat_wide got %0d want 21", ia.stall_cnt); end
    total++; if (ib.state !== 2'd2) begin bad++; $display("FAIL sat_st got %0d want 2", ib.state); end
    dhit = 1'b1; pipe_en = 1'b1; step();
    idle(); settle();
    total++; if (ib.state !== 2'd0) begin bad++; $display("FAIL sat_run got %0d want 0", ib.state); end
    total++; if (ib.stall_cnt !== 4'd15) begin bad++; $display("FAIL sat_hold got %0d want 15", ib.stall_cnt); end
  endtask

  initial begin
    RST = 1'b1; idle();
    #1;
    test_reset();
    test_alu_chain();
    test_youngest();
    test_lu_hit();
    test_lu_miss();
    test_flush();
    test_saturation();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
